// File: rtl/battle_ctl_gen.sv
// Game-control FSM for the two-player ship game. It maps the mouse onto the board and gates ship placement.
// It also runs the shot/reply turn protocol with the peer link and keeps the hit counters and result flags.
module battle_ctl_gen #(
    parameter int GRID_N         = 10,
    parameter int CELL_SIZE      = 32,
    parameter int BOARD_X0       = 608,
    parameter int BOARD_Y0       = 193,
    parameter int SHIP_CELLS     = 11,
    parameter int TIMEOUT_FRAMES = 600
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        mouse_left,
    input  logic [11:0] mouse_xpos,
    input  logic [11:0] mouse_ypos,
    input  logic        start_button,
    input  logic        player_first,
    input  logic [7:0]  ship_count,
    output logic [7:0]  mouse_cell,
    output logic        mouse_in_grid,
    output logic        pick_ship,
    output logic        shot_valid,
    output logic [7:0]  shot_addr,
    input  logic        shot_ready,
    input  logic        result_valid,
    input  logic        result_hit,
    input  logic        rx_shot_valid,
    input  logic [7:0]  rx_shot_addr,
    output logic        rx_shot_ready,
    output logic [7:0]  own_query_addr,
    input  logic        own_hit,
    output logic        reply_valid,
    output logic        reply_hit,
    input  logic        reply_ready,
    output logic        win,
    output logic        lose,
    output logic        timeout_err,
    output logic [7:0]  state_led
);

    // state        | meaning
    // S_IDLE       | waiting for start
    // S_PLACE      | placing ships, click requests a placement
    // S_AIM        | our turn, waiting for a click on an unshot cell
    // S_SHOT_TX    | shot offered to the link
    // S_SHOT_WAIT  | waiting for the peer result, frame timer running
    // S_DEFEND     | waiting for the peer shot
    // S_DEF_LOOKUP | board RAM read in flight
    // S_DEF_REPLY  | reply offered to the link
    // S_GAME_OVER  | result frozen until start
    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_PLACE      = 4'd1,
        S_AIM        = 4'd2,
        S_SHOT_TX    = 4'd3,
        S_SHOT_WAIT  = 4'd4,
        S_DEF_LOOKUP = 4'd5,
        S_DEF_REPLY  = 4'd6,
        S_GAME_OVER  = 4'd7,
        S_DEFEND     = 4'd8
    } state_t;

    localparam int          CELL_SH = $clog2(CELL_SIZE);
    localparam int          MAP_W   = GRID_N * GRID_N;
    localparam int          IDX_W   = $clog2(MAP_W);
    localparam int          TMR_W   = $clog2(TIMEOUT_FRAMES + 1);
    localparam logic [12:0] X_LO    = 13'(BOARD_X0);
    localparam logic [12:0] Y_LO    = 13'(BOARD_Y0);
    localparam logic [12:0] SPAN    = 13'(GRID_N * CELL_SIZE);

    function automatic logic [IDX_W-1:0] cell_idx(input logic [7:0] c);
        return IDX_W'({4'b0, c[7:4]} * 8'(GRID_N) + {4'b0, c[3:0]});
    endfunction

    state_t             state_q, state_d;
    logic               mouse_left_q, start_q;
    logic [7:0]         mouse_cell_q, mouse_cell_d;
    logic               mouse_in_grid_q, mouse_in_grid_d;
    logic               pick_ship_q, pick_ship_d;
    logic [7:0]         shot_addr_q, shot_addr_d;
    logic [7:0]         own_query_addr_q, own_query_addr_d;
    logic               reply_hit_q, reply_hit_d;
    logic [MAP_W-1:0]   shot_map_q, shot_map_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [4:0]         my_hits_q, my_hits_d;
    logic [4:0]         peer_hits_q, peer_hits_d;
    logic               win_q, win_d, lose_q, lose_d, timeout_q, timeout_d;

    logic        click, start_edge, aim_ok, tmr_expire, my_last_hit, peer_last_hit;
    logic [12:0] mx, my, dx, dy;
    logic        in_x, in_y;

    assign click         = mouse_left & ~mouse_left_q;
    assign start_edge    = start_button & ~start_q;
    assign mx            = {1'b0, mouse_xpos};
    assign my            = {1'b0, mouse_ypos};
    assign dx            = mx - X_LO;
    assign dy            = my - Y_LO;
    assign in_x          = (mx >= X_LO) && (dx < SPAN);
    assign in_y          = (my >= Y_LO) && (dy < SPAN);
    assign aim_ok        = click && mouse_in_grid_q && !shot_map_q[cell_idx(mouse_cell_q)];
    assign tmr_expire    = frame_tick && (tmr_q == TMR_W'(1));
    assign my_last_hit   = ({1'b0, my_hits_q} + 6'd1) == 6'(SHIP_CELLS);
    assign peer_last_hit = ({1'b0, peer_hits_q} + 6'd1) == 6'(SHIP_CELLS);

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:       if (start_edge) state_d = S_PLACE;
            S_PLACE:      if (ship_count == 8'(SHIP_CELLS)) state_d = player_first ? S_AIM : S_DEFEND;
            S_AIM:        if (aim_ok) state_d = S_SHOT_TX;
            S_SHOT_TX:    if (shot_ready) state_d = S_SHOT_WAIT;
            S_SHOT_WAIT: begin
                if (result_valid) begin
                    if (result_hit && my_last_hit) state_d = S_GAME_OVER;
                    else if (result_hit)           state_d = S_AIM;
                    else                           state_d = S_DEFEND;
                end else if (tmr_expire) begin
                    state_d = S_GAME_OVER;
                end
            end
            S_DEFEND:     if (rx_shot_valid) state_d = S_DEF_LOOKUP;
            S_DEF_LOOKUP: state_d = S_DEF_REPLY;
            S_DEF_REPLY: begin
                if (reply_ready) begin
                    if (reply_hit_q && peer_last_hit) state_d = S_GAME_OVER;
                    else if (reply_hit_q)             state_d = S_DEFEND;
                    else                              state_d = S_AIM;
                end
            end
            S_GAME_OVER:  if (start_edge) state_d = S_IDLE;
            default:      state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mouse_cell_d     = mouse_cell_q;
        mouse_in_grid_d  = mouse_in_grid_q;
        pick_ship_d      = (state_q == S_PLACE) && click && mouse_in_grid_q;
        shot_addr_d      = shot_addr_q;
        own_query_addr_d = own_query_addr_q;
        reply_hit_d      = reply_hit_q;
        shot_map_d       = shot_map_q;
        tmr_d            = tmr_q;
        my_hits_d        = my_hits_q;
        peer_hits_d      = peer_hits_q;
        win_d            = win_q;
        lose_d           = lose_q;
        timeout_d        = timeout_q;

        if (frame_tick) begin
            mouse_in_grid_d = in_x && in_y;
            if (in_x && in_y) mouse_cell_d = {dy[CELL_SH +: 4], dx[CELL_SH +: 4]};
        end

        case (state_q)
            S_AIM: if (aim_ok) shot_addr_d = mouse_cell_q;
            S_SHOT_TX: begin
                if (shot_ready) begin
                    shot_map_d[cell_idx(shot_addr_q)] = 1'b1;
                    tmr_d = TMR_W'(TIMEOUT_FRAMES);
                end
            end
            S_SHOT_WAIT: begin
                if (frame_tick && tmr_q != '0) tmr_d = tmr_q - TMR_W'(1);
                if (result_valid) begin
                    if (result_hit) begin
                        my_hits_d = (my_hits_q == 5'h1f) ? my_hits_q : my_hits_q + 5'd1;
                        if (my_last_hit) win_d = 1'b1;
                    end
                end else if (tmr_expire) begin
                    timeout_d = 1'b1;
                end
            end
            // Address goes to the RAM combinationally so its data is ready during DEF_LOOKUP.
            S_DEFEND:     if (rx_shot_valid) own_query_addr_d = rx_shot_addr;
            S_DEF_LOOKUP: reply_hit_d = own_hit;
            S_DEF_REPLY: begin
                if (reply_ready && reply_hit_q) begin
                    peer_hits_d = (peer_hits_q == 5'h1f) ? peer_hits_q : peer_hits_q + 5'd1;
                    if (peer_last_hit) lose_d = 1'b1;
                end
            end
            S_GAME_OVER: begin
                if (start_edge) begin
                    win_d       = 1'b0;
                    lose_d      = 1'b0;
                    timeout_d   = 1'b0;
                    my_hits_d   = '0;
                    peer_hits_d = '0;
                    shot_map_d  = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mouse_left_q     <= 1'b0;
            start_q          <= 1'b0;
            mouse_cell_q     <= '0;
            mouse_in_grid_q  <= 1'b0;
            pick_ship_q      <= 1'b0;
            shot_addr_q      <= '0;
            own_query_addr_q <= '0;
            reply_hit_q      <= 1'b0;
            shot_map_q       <= '0;
            tmr_q            <= '0;
            my_hits_q        <= '0;
            peer_hits_q      <= '0;
            win_q            <= 1'b0;
            lose_q           <= 1'b0;
            timeout_q        <= 1'b0;
        end else begin
            mouse_left_q     <= mouse_left;
            start_q          <= start_button;
            mouse_cell_q     <= mouse_cell_d;
            mouse_in_grid_q  <= mouse_in_grid_d;
            pick_ship_q      <= pick_ship_d;
            shot_addr_q      <= shot_addr_d;
            own_query_addr_q <= own_query_addr_d;
            reply_hit_q      <= reply_hit_d;
            shot_map_q       <= shot_map_d;
            tmr_q            <= tmr_d;
            my_hits_q        <= my_hits_d;
            peer_hits_q      <= peer_hits_d;
            win_q            <= win_d;
            lose_q           <= lose_d;
            timeout_q        <= timeout_d;
        end
    end

    // DEFEND has no index of its own on the LEDs; it shares bit 5 with DEF_LOOKUP.
    always_comb begin
        shot_valid    = (state_q == S_SHOT_TX);
        rx_shot_ready = (state_q == S_DEFEND);
        reply_valid   = (state_q == S_DEF_REPLY);
        case (state_q)
            S_IDLE:       state_led = 8'h01;
            S_PLACE:      state_led = 8'h02;
            S_AIM:        state_led = 8'h04;
            S_SHOT_TX:    state_led = 8'h08;
            S_SHOT_WAIT:  state_led = 8'h10;
            S_DEFEND,
            S_DEF_LOOKUP: state_led = 8'h20;
            S_DEF_REPLY:  state_led = 8'h40;
            S_GAME_OVER:  state_led = 8'h80;
            default:      state_led = 8'h01;
        endcase
    end

    assign mouse_cell     = mouse_cell_q;
    assign mouse_in_grid  = mouse_in_grid_q;
    assign pick_ship      = pick_ship_q;
    assign shot_addr      = shot_addr_q;
    assign own_query_addr = own_query_addr_d;
    assign reply_hit      = reply_hit_q;
    assign win            = win_q;
    assign lose           = lose_q;
    assign timeout_err    = timeout_q;

endmodule

// File: tb/tb_battle_ctl_gen.sv
// Scoreboard bench for battle_ctl_gen: expected shot addresses and replies are queued at stimulus time
// and compared when the DUT offers them on the link.
module tb_battle_ctl_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_tick, mouse_left, start_button, player_first;
    logic [11:0] mouse_xpos, mouse_ypos;
    logic [7:0]  ship_count;
    logic [7:0]  mouse_cell;
    logic        mouse_in_grid, pick_ship, shot_valid;
    logic [7:0]  shot_addr;
    logic        shot_ready, result_valid, result_hit, rx_shot_valid;
    logic [7:0]  rx_shot_addr;
    logic        rx_shot_ready;
    logic [7:0]  own_query_addr;
    logic        own_hit, reply_valid, reply_hit, reply_ready;
    logic        win, lose, timeout_err;
    logic [7:0]  state_led;

    logic [255:0] ship_map;
    logic [7:0]   exp_shot_q[$];
    logic         exp_reply_q[$];
    int           n_err = 0;
    int           n_chk = 0;

    always #5 clk = ~clk;

    battle_ctl_gen dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .mouse_left(mouse_left),
        .mouse_xpos(mouse_xpos), .mouse_ypos(mouse_ypos), .start_button(start_button),
        .player_first(player_first), .ship_count(ship_count), .mouse_cell(mouse_cell),
        .mouse_in_grid(mouse_in_grid), .pick_ship(pick_ship), .shot_valid(shot_valid),
        .shot_addr(shot_addr), .shot_ready(shot_ready), .result_valid(result_valid),
        .result_hit(result_hit), .rx_shot_valid(rx_shot_valid), .rx_shot_addr(rx_shot_addr),
        .rx_shot_ready(rx_shot_ready), .own_query_addr(own_query_addr), .own_hit(own_hit),
        .reply_valid(reply_valid), .reply_hit(reply_hit), .reply_ready(reply_ready),
        .win(win), .lose(lose), .timeout_err(timeout_err), .state_led(state_led)
    );

    // own board RAM, one-cycle read latency
    always @(posedge clk) own_hit <= ship_map[own_query_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic press_start();
        start_button = 1'b1;
        @(negedge clk);
        start_button = 1'b0;
        @(negedge clk);
    endtask

    task automatic frame(input int x, input int y);
        mouse_xpos = 12'(x);
        mouse_ypos = 12'(y);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic tick_frame();
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
    endtask

    task automatic click();
        mouse_left = 1'b1;
        @(negedge clk);
        mouse_left = 1'b0;
    endtask

    task automatic aim_cell(input int r, input int c);
        frame(608 + 32 * c + 4, 193 + 32 * r + 4);
        exp_shot_q.push_back({4'(r), 4'(c)});
        click();
    endtask

    task automatic serve_shot(input int dly);
        int guard = 0;
        int cnt = 0;
        logic [7:0] e;
        while (!shot_valid && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        chk("shot_seen", shot_valid, 1);
        if (shot_valid) begin
            e = (exp_shot_q.size() > 0) ? exp_shot_q.pop_front() : 8'hff;
            while (shot_valid && cnt < 10) begin
                cnt++;
                chk("shot_addr", shot_addr, e);
                if (cnt == dly) shot_ready = 1'b1;
                @(negedge clk);
                shot_ready = 1'b0;
            end
            chk("shot_valid_cycles", cnt, dly);
        end
    endtask

    task automatic result(input logic h);
        result_hit   = h;
        result_valid = 1'b1;
        @(negedge clk);
        result_valid = 1'b0;
    endtask

    task automatic defend(input logic [7:0] a);
        int guard = 0;
        logic e;
        chk("rx_ready", rx_shot_ready, 1);
        exp_reply_q.push_back(ship_map[a]);
        rx_shot_addr  = a;
        rx_shot_valid = 1'b1;
        @(negedge clk);
        rx_shot_valid = 1'b0;
        chk("query_addr", own_query_addr, a);
        while (!reply_valid && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        chk("reply_seen", reply_valid, 1);
        e = (exp_reply_q.size() > 0) ? exp_reply_q.pop_front() : 1'bx;
        chk("reply_hit", reply_hit, e);
        reply_ready = 1'b1;
        @(negedge clk);
        reply_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; frame_tick = 0; mouse_left = 0; start_button = 0; player_first = 0;
        mouse_xpos = '0; mouse_ypos = '0; ship_count = '0; shot_ready = 0; result_valid = 0;
        result_hit = 0; rx_shot_valid = 0; rx_shot_addr = '0; reply_ready = 0; ship_map = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_led", state_led, 8'h01);
        chk("rst_cell", mouse_cell, 0);
        chk("rst_in_grid", mouse_in_grid, 0);
        chk("rst_hs", {shot_valid, reply_valid, rx_shot_ready, pick_ship}, 0);
        chk("rst_flags", {win, lose, timeout_err}, 0);
        chk("rst_qaddr", own_query_addr, 0);

        frame(640, 257);
        chk("map_cell", mouse_cell, 8'h21);
        chk("map_in", mouse_in_grid, 1);
        frame(600, 257);
        chk("map_out_x", mouse_in_grid, 0);
        chk("map_hold", mouse_cell, 8'h21);
        frame(927, 512);
        chk("map_corner_cell", mouse_cell, 8'h99);
        chk("map_corner_in", mouse_in_grid, 1);
        frame(928, 300);
        chk("map_edge_x", mouse_in_grid, 0);
        frame(608, 193);
        chk("map_origin", mouse_cell, 8'h00);
        frame(640, 192);
        chk("map_edge_y", mouse_in_grid, 0);

        press_start();
        chk("place_led", state_led, 8'h02);
        frame(640, 257);
        click();
        chk("pick_pulse", pick_ship, 1);
        @(negedge clk);
        chk("pick_clear", pick_ship, 0);
        frame(600, 257);
        click();
        chk("pick_out_grid", pick_ship, 0);
        ship_count   = 8'd11;
        player_first = 1'b1;
        @(negedge clk);
        chk("aim_led", state_led, 8'h04);

        aim_cell(2, 1);
        serve_shot(3);
        chk("wait_led", state_led, 8'h10);
        result(1'b0);
        chk("miss_defend", state_led, 8'h20);
        ship_map[8'h35] = 1'b1;
        defend(8'h35);
        chk("def_hit_stay", state_led, 8'h20);
        defend(8'h36);
        chk("def_miss_aim", state_led, 8'h04);

        frame(640, 257);
        click();
        chk("dup_no_shot", shot_valid, 0);
        @(negedge clk);
        chk("dup_no_shot2", shot_valid, 0);
        chk("dup_led", state_led, 8'h04);
        aim_cell(2, 2);
        serve_shot(1);
        result(1'b1);
        chk("extra_turn", state_led, 8'h04);

        for (int c = 0; c < 10; c++) begin
            aim_cell(5, c);
            serve_shot(1);
            result(1'b1);
            if (c == 8) chk("ten_hits_aim", {state_led, 7'b0, win}, {8'h04, 8'h00});
        end
        chk("win_flag", win, 1);
        chk("win_led", state_led, 8'h80);
        rx_shot_valid = 1'b1;
        click();
        rx_shot_valid = 1'b0;
        chk("frozen_led", state_led, 8'h80);
        chk("frozen_hs", {shot_valid, rx_shot_ready, reply_valid}, 0);
        press_start();
        chk("restart_led", state_led, 8'h01);
        chk("restart_win", win, 0);

        press_start();
        chk("g2_aim", state_led, 8'h04);
        aim_cell(2, 1);
        serve_shot(1);
        repeat (599) tick_frame();
        chk("tie_pre_led", state_led, 8'h10);
        frame_tick   = 1'b1;
        result_valid = 1'b1;
        result_hit   = 1'b0;
        @(negedge clk);
        frame_tick   = 1'b0;
        result_valid = 1'b0;
        chk("tie_result_wins", state_led, 8'h20);
        chk("tie_no_timeout", timeout_err, 0);
        defend(8'h37);
        aim_cell(0, 0);
        serve_shot(2);
        repeat (599) tick_frame();
        chk("to_599_led", state_led, 8'h10);
        chk("to_599_flag", timeout_err, 0);
        tick_frame();
        chk("to_flag", timeout_err, 1);
        chk("to_led", state_led, 8'h80);

        press_start();
        chk("to_clear", timeout_err, 0);
        player_first = 1'b0;
        press_start();
        chk("g3_defend", state_led, 8'h20);
        for (int i = 0; i < 11; i++) begin
            ship_map[8'(8'h40 + i)] = 1'b1;
            defend(8'(8'h40 + i));
            if (i == 9) chk("ten_peer_hits", {state_led, 7'b0, lose}, {8'h20, 8'h00});
        end
        chk("lose_flag", {win, lose}, 2'b01);
        chk("lose_led", state_led, 8'h80);

        press_start();
        press_start();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_led", state_led, 8'h01);
        chk("midrst_flags", {win, lose, timeout_err}, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
